// File: rtl/dc_ipu_filter_phase_ctrl_pkg.sv
// Shared types and helpers for the IPU scaler filter phase sequencer (DDA).
package dc_ipu_filter_pkg;

  localparam int WEIGHT_WIDTH_DEF       = 12;
  localparam int WEIGHT_FRACT_WIDTH_DEF = 8;
  localparam int STEP_INT_WIDTH_DEF     = 3;
  localparam int CNT_WIDTH_DEF          = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } phase_state_t;

  typedef struct packed {
    logic [15:0] ipart;
    logic [15:0] fpart;
  } step_sum_t;

  // Adds an unsigned fraction-only accumulator to the step and splits the
  // result at frac_w into integer (pixels to consume) and fractional parts.
  function automatic step_sum_t step_sum(input logic [15:0] acc,
                                         input logic [15:0] step,
                                         input int unsigned frac_w);
    step_sum_t   r;
    logic [31:0] s;
    logic [31:0] mask;
    s       = {16'd0, acc} + {16'd0, step};
    mask    = (32'd1 << frac_w) - 32'd1;
    r.fpart = 16'(s & mask);
    r.ipart = 16'(s >> frac_w);
    return r;
  endfunction

endpackage

// File: rtl/dc_ipu_filter_phase_ctrl_if.sv
// Phase handshake bus from the phase sequencer to the filter weights / tap line buffer.
interface dc_ipu_filter_phase_ctrl_if
  import dc_ipu_filter_pkg::*;
#(
  parameter int WEIGHT_WIDTH   = WEIGHT_WIDTH_DEF,
  parameter int STEP_INT_WIDTH = STEP_INT_WIDTH_DEF
);
  logic                           phase_valid;
  logic                           phase_ready;
  logic signed [WEIGHT_WIDTH-1:0] alpha;
  logic [STEP_INT_WIDTH:0]        src_adv;
  logic                           phase_last;

  modport master (
    output phase_valid, alpha, src_adv, phase_last,
    input  phase_ready
  );

  modport slave (
    input  phase_valid, alpha, src_adv, phase_last,
    output phase_ready
  );
endinterface

// File: rtl/dc_ipu_filter_phase_ctrl.sv
// Per-line phase sequencer for the 4-tap polyphase scaler: issues alpha and source advance per output pixel.
// Optional macro DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN adds cfg_init_phase to preset the accumulator.
module dc_ipu_filter_phase_ctrl
  import dc_ipu_filter_pkg::*;
#(
  parameter int WEIGHT_WIDTH       = WEIGHT_WIDTH_DEF,
  parameter int WEIGHT_FRACT_WIDTH = WEIGHT_FRACT_WIDTH_DEF,
  parameter int STEP_INT_WIDTH     = STEP_INT_WIDTH_DEF,
  parameter int CNT_WIDTH          = CNT_WIDTH_DEF
)(
  input  logic                                       clk,
  input  logic                                       nreset,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [STEP_INT_WIDTH+WEIGHT_FRACT_WIDTH-1:0] cfg_step,
  input  logic [CNT_WIDTH-1:0]                       cfg_out_width,
`ifdef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
  input  logic [WEIGHT_FRACT_WIDTH-1:0]              cfg_init_phase,
`endif
  output logic                                       busy,
  output logic                                       line_done,
  dc_ipu_filter_phase_ctrl_if.master                 phase_if
);

  localparam int STEP_W = STEP_INT_WIDTH + WEIGHT_FRACT_WIDTH;

  phase_state_t                  state_q, state_d;
  logic [WEIGHT_FRACT_WIDTH-1:0] acc_q, acc_d;
  logic [STEP_W-1:0]             step_q, step_d;
  logic [CNT_WIDTH-1:0]          width_q, width_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;

  step_sum_t                     sum_s;
  logic                          valid_s;
  logic                          hs_s;
  logic                          last_s;
  logic [WEIGHT_FRACT_WIDTH-1:0] init_phase_s;
  logic                          unused_sum_bits;

`ifdef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
  assign init_phase_s = cfg_init_phase;
`else
  assign init_phase_s = '0;
`endif

  assign sum_s   = step_sum(16'(acc_q), 16'(step_q), WEIGHT_FRACT_WIDTH);
  assign last_s  = (cnt_q == width_q - CNT_WIDTH'(1));
  // Abort wins over a handshake in the same cycle, so valid is masked by it.
  assign valid_s = (state_q == RUN) && !abort;
  assign hs_s    = valid_s && phase_if.phase_ready;

  assign unused_sum_bits = ^{sum_s.ipart[15:STEP_INT_WIDTH+1],
                             sum_s.fpart[15:WEIGHT_FRACT_WIDTH]};

  assign phase_if.phase_valid = valid_s;
  assign phase_if.alpha       = $signed({{(WEIGHT_WIDTH-WEIGHT_FRACT_WIDTH){1'b0}}, acc_q});
  assign phase_if.src_adv     = sum_s.ipart[STEP_INT_WIDTH:0];
  assign phase_if.phase_last  = last_s;
  assign busy                 = (state_q != IDLE);
  assign line_done            = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    width_d = width_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d  = cfg_step;
          width_d = cfg_out_width;
          acc_d   = init_phase_s;
          cnt_d   = '0;
          state_d = (abort || (cfg_out_width == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (hs_s) begin
          acc_d = sum_s.fpart[WEIGHT_FRACT_WIDTH-1:0];
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_s) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      width_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      width_q <= width_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dc_ipu_filter_phase_ctrl.sv
// Self-checking bench for dc_ipu_filter_phase_ctrl against an arithmetic model of the phase sequence.
module tb_dc_ipu_filter_phase_ctrl;

  localparam int WW = 12;
  localparam int FW = 8;
  localparam int SI = 3;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          nreset;
  logic          start;
  logic          abort;
  logic [10:0]   cfg_step;
  logic [12:0]   cfg_out_width;
`ifdef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
  logic [7:0]    cfg_init_phase;
`endif
  logic          busy;
  logic          line_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dc_ipu_filter_phase_ctrl_if #(.WEIGHT_WIDTH(WW), .STEP_INT_WIDTH(SI)) pif ();

  dc_ipu_filter_phase_ctrl #(
    .WEIGHT_WIDTH(WW), .WEIGHT_FRACT_WIDTH(FW), .STEP_INT_WIDTH(SI), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .start         (start),
    .abort         (abort),
    .cfg_step      (cfg_step),
    .cfg_out_width (cfg_out_width),
`ifdef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
    .cfg_init_phase(cfg_init_phase),
`endif
    .busy          (busy),
    .line_done     (line_done),
    .phase_if      (pif.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output k sits at source position init + k*step (fixed point, FW fraction bits).
  function automatic int exp_alpha(input int init, input int step, input int k);
    return (init + k * step) % (1 << FW);
  endfunction

  function automatic int exp_adv(input int init, input int step, input int k);
    return ((init + (k + 1) * step) >> FW) - ((init + k * step) >> FW);
  endfunction

  // ready_mode: 0 always ready, 1 alternate 1/0, 2 random. abort_at: phase index to abort on, -1 none.
  task automatic run_line(input int step, input int width, input int ready_mode,
                          input int abort_at, input int init, input bit noise);
    int  k;
    int  cyc;
    int  ini;
    bit  aborted;
    logic rdy;
    ini = init;
`ifndef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
    ini = 0;
`endif
    @(negedge clk);
    start         = 1'b1;
    abort         = 1'b0;
    cfg_step      = 11'(step);
    cfg_out_width = 13'(width);
`ifdef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
    cfg_init_phase = 8'(init);
`endif
    #1;
    chk("idle_busy", busy, 1'b0);
    @(negedge clk);
    start    = 1'b0;
    cfg_step = 11'($urandom);
    k        = 0;
    cyc      = 0;
    aborted  = 1'b0;
    while (k < width && cyc < 400 && !aborted) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom % 2);
      endcase
      if (k == abort_at) rdy = 1'b1;
      pif.phase_ready = rdy;
      if (noise) begin
        start         = ($urandom % 3 == 0);
        cfg_step      = 11'($urandom);
        cfg_out_width = 13'($urandom % 8);
      end
      abort = (k == abort_at);
      #1;
      if (abort) begin
        chk("abort_valid", pif.phase_valid, 1'b0);
        aborted = 1'b1;
      end else begin
        chk($sformatf("valid[%0d]", k), pif.phase_valid, 1'b1);
        chk($sformatf("alpha[%0d]", k), pif.alpha, exp_alpha(ini, step, k));
        chk($sformatf("src_adv[%0d]", k), pif.src_adv, exp_adv(ini, step, k));
        chk($sformatf("last[%0d]", k), pif.phase_last, (k == width - 1));
        chk("run_busy", busy, 1'b1);
        chk("run_no_done", line_done, 1'b0);
        if (rdy) k++;
      end
      cyc++;
      @(negedge clk);
    end
    if (!aborted) chk("handshake_count", k, width);
    start           = 1'b0;
    abort           = 1'b0;
    pif.phase_ready = 1'($urandom % 2);
    #1;
    chk("line_done", line_done, 1'b1);
    chk("done_valid", pif.phase_valid, 1'b0);
    chk("done_busy", busy, 1'b1);
    @(negedge clk);
    #1;
    chk("done_pulse_end", line_done, 1'b0);
    chk("idle_after", busy, 1'b0);
  endtask

  initial begin
    nreset          = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    cfg_step        = '0;
    cfg_out_width   = '0;
`ifdef DC_IPU_FILTER_PHASE_CTRL_INIT_PHASE_EN
    cfg_init_phase  = '0;
`endif
    pif.phase_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", pif.phase_valid, 1'b0);
    chk("rst_alpha", pif.alpha, 0);
    chk("rst_src_adv", pif.src_adv, 0);
    chk("rst_last", pif.phase_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", line_done, 1'b0);
    nreset = 1'b1;

    run_line(12'h080, 4, 0, -1, 0, 1'b0);
    run_line(12'h180, 3, 0, -1, 0, 1'b0);
    run_line(12'h200, 5, 1, -1, 0, 1'b0);
    run_line(12'h100, 0, 0, -1, 0, 1'b0);
    run_line(12'h0C0, 6, 0, 1, 0, 1'b0);
    run_line(12'h080, 2, 0, -1, 8'h40, 1'b0);
    run_line(12'h000, 5, 2, -1, 8'h33, 1'b0);
    run_line(12'h7FF, 6, 2, -1, 8'hFF, 1'b1);

    // Abort arriving together with start from IDLE.
    @(negedge clk);
    start         = 1'b1;
    abort         = 1'b1;
    cfg_step      = 11'h080;
    cfg_out_width = 13'd5;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("start_abort_valid", pif.phase_valid, 1'b0);
    chk("start_abort_done", line_done, 1'b1);
    @(negedge clk);
    #1;
    chk("start_abort_idle", busy, 1'b0);

    for (int i = 0; i < 25; i++) begin
      int w;
      int ab;
      w  = 1 + int'($urandom % 24);
      ab = ($urandom % 5 == 0) ? int'($urandom % w) : -1;
      run_line(int'($urandom % 2048), w, 2, ab, int'($urandom % 256), 1'b1);
    end

    // Asynchronous reset in the middle of a line.
    @(negedge clk);
    start         = 1'b1;
    cfg_step      = 11'h123;
    cfg_out_width = 13'd10;
    @(negedge clk);
    start           = 1'b0;
    pif.phase_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_rst_valid", pif.phase_valid, 1'b0);
    chk("mid_rst_alpha", pif.alpha, 0);
    chk("mid_rst_src_adv", pif.src_adv, 0);
    chk("mid_rst_last", pif.phase_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", line_done, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", line_done, 1'b0);
      chk("post_rst_idle", busy, 1'b0);
    end
    run_line(12'h0A0, 4, 2, -1, 8'h40, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
